// File: rtl/babbage_inv_rtl.sv
// babbage_inv_rtl: finds the smallest n in 0..15 with f(n) = 2n^2 + 3n + 5 >= y.
// f is stepped by forward differencing (f += g, g += 4), so no multiplier is needed.
// If y exceeds f(15) = 500, the result is n = 15 with the overflow flag set.
module babbage_inv_rtl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] y,
  output logic       ready,
  output logic       done_tick,
  output logic [3:0] n_out,
  output logic       exact,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OP   = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] y_reg_q, y_reg_d;
  logic [9:0] f_q, f_d;
  logic [6:0] g_q, g_d;
  logic [3:0] n_q, n_d;
  logic [3:0] n_out_q, n_out_d;
  logic       exact_q, exact_d;
  logic       ovf_q, ovf_d;

  // State and datapath registers; reset aborts any run in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      y_reg_q <= 10'd0;
      f_q     <= 10'd0;
      g_q     <= 7'd0;
      n_q     <= 4'd0;
      n_out_q <= 4'd0;
      exact_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_reg_q <= y_reg_d;
      f_q     <= f_d;
      g_q     <= g_d;
      n_q     <= n_d;
      n_out_q <= n_out_d;
      exact_q <= exact_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, difference stepping and result capture; results only move on op-to-done
  always_comb begin
    state_d   = state_q;
    y_reg_d   = y_reg_q;
    f_d       = f_q;
    g_d       = g_q;
    n_d       = n_q;
    n_out_d   = n_out_q;
    exact_d   = exact_q;
    ovf_d     = ovf_q;
    ready     = 1'b0;
    done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          y_reg_d = y;
          f_d     = 10'd5;
          g_d     = 7'd5;
          n_d     = 4'd0;
          state_d = OP;
        end
      end
      OP: begin
        if (f_q >= y_reg_q) begin
          n_out_d = n_q;
          exact_d = (f_q == y_reg_q);
          ovf_d   = 1'b0;
          state_d = DONE;
        end else if (n_q == 4'd15) begin
          n_out_d = 4'd15;
          exact_d = 1'b0;
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          f_d = f_q + {3'b000, g_q};
          g_d = g_q + 7'd4;
          n_d = n_q + 4'd1;
        end
      end
      DONE: begin
        done_tick = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign n_out = n_out_q;
  assign exact = exact_q;
  assign ovf   = ovf_q;

endmodule
